// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode 7-segment driver for a chain of BCD digits.
// Each digit slot begins with a short all-off guard; content is snapshotted once per frame.
module bcd_display_scan #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 2
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [4*DIGITS-1:0]   Din,
   input  logic [DIGITS-1:0]     Dp_in,
   input  logic                  Blank_en,
   output logic [6:0]            Seg,
   output logic                  Dp,
   output logic [DIGITS-1:0]     An
);

   localparam int DW = $clog2(REFRESH_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DW-1:0]            div;
   logic [IW-1:0]            idx;
   logic [DIGITS-1:0][3:0]   snap_d;
   logic [DIGITS-1:0]        snap_dp;

   logic [DIGITS-1:0]        lz;
   logic                     run;
   logic [DIGITS-1:0]        oh;
   logic                     in_guard;
   logic [6:0]               seg_n;
   logic                     dp_n;
   logic [DIGITS-1:0]        an_n;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = 7'b0111111;
      endcase
   endfunction

   always_comb begin
      // lz[i]: snapshot digits i..DIGITS-1 are all zero
      run = 1'b1;
      lz  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run   = run & (snap_d[i] == 4'd0);
         lz[i] = run;
      end
      oh       = '0;
      oh[idx]  = 1'b1;
      in_guard = (div < DW'(GUARD));
      seg_n    = 7'b1111111;
      dp_n     = 1'b1;
      an_n     = '1;
      if (!in_guard) begin
         an_n = ~oh;
         dp_n = ~snap_dp[idx];
         if (!(Blank_en && (idx != '0) && lz[idx]))
            seg_n = seg_of(snap_d[idx]);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         div     <= '0;
         idx     <= '0;
         snap_d  <= '0;
         snap_dp <= '0;
         Seg     <= 7'b1111111;
         Dp      <= 1'b1;
         An      <= '1;
      end else begin
         if (div == DW'(REFRESH_DIV - 1)) begin
            div <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            div <= div + 1'b1;
         end
         // Frame start: this slot is in guard, so the new content only appears once lit.
         if (div == '0 && idx == '0) begin
            snap_d  <= Din;
            snap_dp <= Dp_in;
         end
         Seg <= seg_n;
         Dp  <= dp_n;
         An  <= an_n;
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: 4 digits, 4-cycle slots, 1-cycle guard.
// Per-cycle expectations are queued by the driver and checked on the falling edge.
module tb_bcd_display_scan;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;

   logic        Clk, Reset, Blank_en, Dp;
   logic [15:0] Din;
   logic [3:0]  Dp_in, An;
   logic [6:0]  Seg;

   bcd_display_scan #(.DIGITS(4), .REFRESH_DIV(4), .GUARD(1)) dut (
      .Clk(Clk), .Reset(Reset), .Din(Din), .Dp_in(Dp_in), .Blank_en(Blank_en),
      .Seg(Seg), .Dp(Dp), .An(An)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string      name;
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
   } exp_t;

   typedef struct {
      string       name;
      logic [15:0] din;
      logic [3:0]  dpi;
      logic        ben;
      logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
      logic [3:0]  dpo;    // active-low expected Dp per digit
   } vec_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   done   = 1'b0;

   always @(negedge Clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_chk++;
         if ({Seg, Dp, An} !== {e.seg, e.dp, e.an}) begin
            n_fail++;
            $display("FAIL %s: got Seg=%b Dp=%b An=%b, want Seg=%b Dp=%b An=%b",
                     e.name, Seg, Dp, An, e.seg, e.dp, e.an);
         end
      end
   end

   initial begin
      #50000;
      if (!done) begin
         n_fail++;
         $display("FAIL timeout: stimulus did not complete");
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
         $finish;
      end
   end

   task automatic tick(input string nm, input logic [6:0] s, input logic d, input logic [3:0] a);
      exp_t e;
      e.name = nm; e.seg = s; e.dp = d; e.an = a;
      q.push_back(e);
      @(negedge Clk);
   endtask

   // pos = cycle within the 16-cycle frame; pos%4==0 is the guard cycle of each slot
   task automatic scan_tick(input string nm, input int pos, input logic [27:0] segs, input logic [3:0] dpo);
      int i, dv;
      logic [3:0] an;
      i  = (pos / 4) % 4;
      dv = pos % 4;
      an = 4'b0001 << i;
      an = ~an;
      if (dv == 0) tick($sformatf("%s p%0d", nm, pos), SB, 1'b1, 4'hF);
      else         tick($sformatf("%s p%0d", nm, pos), segs[i*7 +: 7], dpo[i], an);
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{"1234",        16'h1234, 4'b0000, 1'b0, {S1, S2, S3, S4}, 4'b1111};
      vecs[1] = '{"0070 blank",  16'h0070, 4'b0000, 1'b1, {SB, SB, S7, S0}, 4'b1111};
      vecs[2] = '{"0000 blank",  16'h0000, 4'b0000, 1'b1, {SB, SB, SB, S0}, 4'b1111};
      vecs[3] = '{"00A0 dp",     16'h00A0, 4'b0010, 1'b1, {SB, SB, SD, S0}, 4'b1101};
      vecs[4] = '{"0000 noblank",16'h0000, 4'b0000, 1'b0, {S0, S0, S0, S0}, 4'b1111};
      vecs[5] = '{"9865 dp",     16'h9865, 4'b1001, 1'b0, {S9, S8, S6, S5}, 4'b0110};
      vecs[6] = '{"A00F blank",  16'hA00F, 4'b0000, 1'b1, {SD, S0, S0, SD}, 4'b1111};
      vecs[7] = '{"0100 blank",  16'h0100, 4'b0100, 1'b1, {SB, S1, S0, S0}, 4'b1011};

      Reset = 1'b1; Din = 16'h1234; Dp_in = 4'b0; Blank_en = 1'b0;
      repeat (3) tick("reset", SB, 1'b1, 4'hF);
      n_chk++;
      if ({Seg, Dp, An} !== {SB, 1'b1, 4'hF}) begin
         n_fail++;
         $display("FAIL reset state: got Seg=%b Dp=%b An=%b", Seg, Dp, An);
      end
      Reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         Din = vecs[v].din; Dp_in = vecs[v].dpi; Blank_en = vecs[v].ben;
         for (int p = 0; p < 16; p++) scan_tick(vecs[v].name, p, vecs[v].segs, vecs[v].dpo);
      end

      // Din change mid-frame must not tear the frame in progress
      Din = 16'h1234; Dp_in = 4'b0; Blank_en = 1'b0;
      for (int p = 0; p < 8; p++) scan_tick("tear old", p, {S1, S2, S3, S4}, 4'hF);
      Din = 16'h5678;
      for (int p = 8; p < 16; p++) scan_tick("tear hold", p, {S1, S2, S3, S4}, 4'hF);
      for (int p = 0; p < 16; p++) scan_tick("tear new", p, {S5, S6, S7, S8}, 4'hF);

      // Blank_en acts immediately, not at the next snapshot
      Din = 16'h0070; Blank_en = 1'b1;
      for (int p = 0; p < 8; p++) scan_tick("live blank on", p, {SB, SB, S7, S0}, 4'hF);
      Blank_en = 1'b0;
      for (int p = 8; p < 16; p++) scan_tick("live blank off", p, {S0, S0, S7, S0}, 4'hF);

      // One-cycle reset at idx=2/div=2 restarts the scan with a fresh snapshot
      Din = 16'h5678;
      for (int p = 0; p < 5; p++) scan_tick("pre reset", p, {S5, S6, S7, S8}, 4'hF);
      Din = 16'h4321;
      for (int p = 5; p < 10; p++) scan_tick("pre reset hold", p, {S5, S6, S7, S8}, 4'hF);
      Reset = 1'b1;
      tick("mid reset", SB, 1'b1, 4'hF);
      Reset = 1'b0;
      for (int p = 0; p < 16; p++) scan_tick("post reset", p, {S4, S3, S2, S1}, 4'hF);

      #1;
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
